fcomp_sched: RTL and testbench
==============================

# fcomp_sched

Round-robin scheduler that shares one combinational single-precision float comparator (`fcomp`-style: `opf`, `regb`, `regc` in; `gt`, `eq`, `lt` out) among `N_REQ` neuron-update requesters. Each requester hands over an operand pair and a relation code through a valid/ready handshake. The block registers the operands, drives the shared comparator for one cycle and captures its flags. It then returns the flags plus a single "relation holds" bit to the granted requester through a valid/ready response handshake. It sits between the per-neuron threshold/update logic and the single comparator instance.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `IDX_W`, `$clog2(N_REQ)`, grant index width

Ports:
- `clk` input 1: clock, all state on rising edge
- `rst` input 1: asynchronous, active-high reset
- `req_valid` input N_REQ: requester i has an operand pair pending
- `req_ready` output N_REQ: one-hot accept strobe, combinational
- `req_op` input 2*N_REQ: relation per requester, 0=GT, 1=EQ, 2=LT, 3=reserved
- `req_b`, `req_c` input 32*N_REQ: IEEE-754 single operands (b compared against c)
- `rsp_valid` output N_REQ: one-hot result valid
- `rsp_ready` input N_REQ: requester consumes result
- `rsp_flags` output 3: registered {gt,eq,lt}, shared by all requesters
- `rsp_hit` output 1: registered, 1 when the requested relation holds
- `cmp_op` output 2: to comparator `opf`
- `cmp_b`, `cmp_c` output 32: to comparator `regb`, `regc`
- `cmp_gt`, `cmp_eq`, `cmp_lt` input 1: from comparator, combinational
- `busy` output 1: state != IDLE
- `cmp_count` output 16: completed transactions, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - Grant `g` = first i with `req_valid[i]`=1, searching from `ptr` upward, mod N_REQ.
  - `req_ready[g]`=1 this cycle only.
  - At the edge, capture `req_op[g]`, `req_b[g]`, `req_c[g]` and `g`, then go to CMP.
  - No valid requester: stay in IDLE and keep all outputs at their idle values.
- CMP:
  - `cmp_*` outputs driven from the captured registers.
  - At the edge, `rsp_flags` ← {cmp_gt,cmp_eq,cmp_lt}.
  - `rsp_hit` ← flag selected by op: GT→gt, EQ→eq, LT→lt, op 3→0.
  - Go to RESP.
- RESP:
  - `rsp_valid[g]`=1; flags and hit held stable.
  - On `rsp_ready[g]`=1: `ptr` ← (g+1) mod N_REQ, `cmp_count` += 1, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is 0 outside IDLE. A requester's `req_*` may change freely after its accept.
- `cmp_*` outputs are 0 in IDLE.
- A requester that deasserts `req_valid` before grant is skipped. No starvation: every valid requester is granted within N_REQ transactions.
- `req_valid[g]` re-asserted in the same cycle as its own response handshake: the round-robin pointer has moved past g, so g is served after the other valid requesters.

## Timing
- Reset values: state IDLE, `ptr`=0, `rsp_valid`=0, `rsp_flags`=0, `rsp_hit`=0, `cmp_op/b/c`=0, `cmp_count`=0, `busy`=0, `req_ready`=0.
- Latency: accept edge (cycle 0) → `rsp_valid` high in cycle 2.
- Minimum interval between accepts is 3 cycles when `rsp_ready` is tied high.
- `rsp_valid` stays high until the handshake. `rsp_ready` asserted early, before `rsp_valid`, is honoured in the first RESP cycle.
- `rst` asserted mid-transaction clears state immediately and asynchronously. The pending transaction is dropped without a response and `cmp_count` is not incremented.

## Configuration
- `FCOMP_SCHED_NAN_EN` defined:
  - During CMP, if either captured operand is NaN (exp=0xFF, mantissa≠0), the block forces `rsp_flags`=0 and `rsp_hit`=0, overriding the comparator outputs.
  - It also adds output `nan_seen` (1 bit), a sticky flag set in that case and cleared only by `rst`.
- Undefined: comparator flags pass through unchanged, and the `nan_seen` port does not exist.

## Test plan
- Single request: req 0, op GT, b=0x40000000 (2.0), c=0x3F800000 (1.0), comparator model attached → `rsp_valid[0]` in cycle 2 after accept, flags=3'b100, hit=1, `cmp_count`=1.
- Round robin: all four requesters valid continuously, `rsp_ready` tied 1 → grant order 0,1,2,3,0; one accept every 3 cycles.
- Backpressure: req 2, op LT, b=0xBF800000 (-1.0), c=0x00000000; `rsp_ready` held low 5 cycles → `rsp_valid[2]`, flags=3'b001 and hit=1 held stable; no new accept until the handshake.
- Reserved op: op=3, b=c=0x3F800000 → flags=3'b010, hit=0.
- Reset mid-op: assert `rst` during CMP → all outputs return to reset values the same cycle; after release, req 0 is granted first.
- With `FCOMP_SCHED_NAN_EN`: b=0x7FC00000, op EQ → flags=0, hit=0, `nan_seen`=1 and still 1 after the next normal transaction.

Source files
------------

// File: rtl/fcomp_sched.sv
// Round-robin arbiter sharing one combinational float comparator among N_REQ requesters.
// Optional FCOMP_SCHED_NAN_EN: NaN operands force zero flags/hit and set a sticky nan_seen.
module fcomp_sched #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [32*N_REQ-1:0]  req_c,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [2:0]           rsp_flags,
  output logic                 rsp_hit,
  output logic [1:0]           cmp_op,
  output logic [31:0]          cmp_b,
  output logic [31:0]          cmp_c,
  input  logic                 cmp_gt,
  input  logic                 cmp_eq,
  input  logic                 cmp_lt,
  output logic                 busy,
  output logic [15:0]          cmp_count
`ifdef FCOMP_SCHED_NAN_EN
  , output logic               nan_seen
`endif
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, g_q, g_d, grant;
  logic             found;
  logic [1:0]       op_q, op_d;
  logic [31:0]      b_q, b_d, c_q, c_d;
  logic [2:0]       flags_q, flags_d;
  logic             hit_q, hit_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             nan_q, nan_d;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Walk offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    op_d    = op_q;
    b_d     = b_q;
    c_d     = c_q;
    flags_d = flags_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    nan_d   = nan_q;
    case (state_q)
      IDLE: if (found) begin
        g_d     = grant;
        op_d    = req_op[2*int'(grant) +: 2];
        b_d     = req_b[32*int'(grant) +: 32];
        c_d     = req_c[32*int'(grant) +: 32];
        state_d = CMP;
      end
      CMP: begin
        flags_d = {cmp_gt, cmp_eq, cmp_lt};
        case (op_q)
          2'd0:    hit_d = cmp_gt;
          2'd1:    hit_d = cmp_eq;
          2'd2:    hit_d = cmp_lt;
          default: hit_d = 1'b0;
        endcase
`ifdef FCOMP_SCHED_NAN_EN
        if (is_nan(b_q) || is_nan(c_q)) begin
          flags_d = 3'b000;
          hit_d   = 1'b0;
          nan_d   = 1'b1;
        end
`endif
        state_d = RESP;
      end
      RESP: if (rsp_ready[g_q]) begin
        ptr_d   = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        cnt_d   = cnt_q + 16'd1;
        flags_d = 3'b000;
        hit_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      op_q    <= '0;
      b_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      op_q    <= op_d;
      b_q     <= b_d;
      c_q     <= c_d;
      flags_q <= flags_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      nan_q   <= nan_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && found && !rst) req_ready[grant] = 1'b1;
    if (state_q == RESP) rsp_valid[g_q] = 1'b1;
  end

  assign cmp_op    = (state_q == CMP) ? op_q : 2'd0;
  assign cmp_b     = (state_q == CMP) ? b_q  : 32'd0;
  assign cmp_c     = (state_q == CMP) ? c_q  : 32'd0;
  assign busy      = (state_q != IDLE);
  assign rsp_flags = flags_q;
  assign rsp_hit   = hit_q;
  assign cmp_count = cnt_q;
`ifdef FCOMP_SCHED_NAN_EN
  assign nan_seen  = nan_q;
`else
  logic unused_nan;
  assign unused_nan = nan_q ^ is_nan(b_q);
`endif

endmodule

// File: tb/tb_fcomp_sched.sv
// Randomized bench for fcomp_sched against a transaction-level round-robin and float-compare model.
module tb_fcomp_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]   req_op;
  logic [127:0] req_b, req_c;
  logic [2:0]   rsp_flags;
  logic         rsp_hit, busy, cmp_gt, cmp_eq, cmp_lt;
  logic [1:0]   cmp_op;
  logic [31:0]  cmp_b, cmp_c;
  logic [15:0]  cmp_count;
`ifdef FCOMP_SCHED_NAN_EN
  logic         nan_seen;
`endif

  fcomp_sched #(.N_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_flags(rsp_flags), .rsp_hit(rsp_hit),
    .cmp_op(cmp_op), .cmp_b(cmp_b), .cmp_c(cmp_c),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .busy(busy), .cmp_count(cmp_count)
`ifdef FCOMP_SCHED_NAN_EN
    , .nan_seen(nan_seen)
`endif
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0, cyc = 0;
  int m_ptr = 0, m_cnt = 0, last_acc = 0;
  logic [1:0]  op_a[4];
  logic [31:0] b_a[4], c_a[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Ordering key: IEEE single mapped so unsigned compare matches numeric order; +0 == -0.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    if (x[30:0] == 31'd0) return 32'h8000_0000;
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic [2:0] fref(input logic [31:0] b, input logic [31:0] c);
    if (fnan(b) || fnan(c)) return 3'b000;
    if (fkey(b) > fkey(c)) return 3'b100;
    if (fkey(b) == fkey(c)) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic href(input logic [1:0] op, input logic [2:0] f);
    case (op)
      2'd0: return f[2];
      2'd1: return f[1];
      2'd2: return f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_f();
    case ($urandom_range(0, 10))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h3F80_0000;
      3: return 32'hBF80_0000;
      4: return 32'h4000_0000;
      5: return 32'h7F80_0000;
      6: return 32'hFF80_0000;
      7: return 32'h7FC0_0000;
      8: return 32'h0000_0001;
      9: return 32'hC000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Single comparator instance shared through the DUT.
  assign {cmp_gt, cmp_eq, cmp_lt} = fref(cmp_b, cmp_c);

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2] = op_a[i];
      req_b[32*i +: 32] = b_a[i];
      req_c[32*i +: 32] = c_a[i];
    end
  endtask

  task automatic randomize_req(input int i);
    op_a[i] = 2'($urandom_range(0, 3));
    b_a[i]  = rnd_f();
    c_a[i]  = ($urandom_range(0, 3) == 0) ? b_a[i] : rnd_f();
  endtask

  // Called right after a negedge with the DUT idle; leaves it idle after the handshake.
  task automatic do_txn(input logic [3:0] mask, input int delay, input bit chk_iv);
    int g;
    logic [3:0] bg;
    logic [2:0] ef;
    logic eh;
    logic [1:0] eop;
    logic [31:0] eb, ec;
    g = -1;
    for (int k = 0; k < 4; k++)
      if (g < 0 && mask[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    bg  = 4'b0001 << g;
    eop = op_a[g]; eb = b_a[g]; ec = c_a[g];
    ef  = fref(eb, ec);
    eh  = href(eop, ef);
    req_valid = mask; rsp_ready = '0; pack();
    #1;
    chk("grant", req_ready, bg);
    if (chk_iv) chk("accept_interval", cyc - last_acc, 3);
    last_acc = cyc;
    @(negedge clk);
    // The accepted requester's inputs are no longer relevant.
    req_valid[g] = 1'b0; b_a[g] = $urandom; c_a[g] = $urandom; op_a[g] = ~op_a[g]; pack();
    rsp_ready = (delay == 0) ? (4'($urandom) | bg) : (4'($urandom) & ~bg);
    #1;
    chk("cmp_busy", busy, 1);
    chk("cmp_rsp_valid", rsp_valid, 0);
    chk("cmp_req_ready", req_ready, 0);
    chk("cmp_op", cmp_op, eop);
    chk("cmp_b", cmp_b, eb);
    chk("cmp_c", cmp_c, ec);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk); #1;
      chk("rsp_valid", rsp_valid, bg);
      chk("rsp_flags", rsp_flags, ef);
      chk("rsp_hit", rsp_hit, eh);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_count", cmp_count, 16'(m_cnt));
      if (k == delay) begin
        rsp_ready = 4'($urandom) | bg;
        req_valid = mask;
      end else rsp_ready = 4'($urandom) & ~bg;
    end
    @(negedge clk); #1;
    m_cnt++;
    m_ptr = (g + 1) % 4;
    chk("done_count", cmp_count, 16'(m_cnt));
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < 4; i++) begin op_a[i] = '0; b_a[i] = '0; c_a[i] = '0; end
    pack();
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_hit", rsp_hit, 0);
    chk("rst_count", cmp_count, 0);
    chk("rst_cmp_b", cmp_b, 0);
    @(negedge clk); rst = 1'b0;

    // Idle: no requester valid.
    repeat (3) begin
      @(negedge clk); #1;
      chk("idle_req_ready", req_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmp", {cmp_op, cmp_b, cmp_c}, 0);
    end

    // Single request: 2.0 > 1.0.
    op_a[0] = 2'd0; b_a[0] = 32'h4000_0000; c_a[0] = 32'h3F80_0000;
    do_txn(4'b0001, 0, 0);
    chk("single_count", cmp_count, 1);

    // Round robin, all valid, rsp_ready early.
    for (int i = 0; i < 4; i++) randomize_req(i);
    do_txn(4'b1111, 0, 0);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++) randomize_req(i);
      do_txn(4'b1111, 0, 1);
    end

    // Backpressure: -1.0 < 0.0 held for 5 cycles.
    op_a[2] = 2'd2; b_a[2] = 32'hBF80_0000; c_a[2] = 32'h0000_0000;
    do_txn(4'b0100, 5, 0);

    // Reserved op.
    op_a[1] = 2'd3; b_a[1] = 32'h3F80_0000; c_a[1] = 32'h3F80_0000;
    do_txn(4'b0010, 1, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) randomize_req(i);
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 4), 0);
    end

    // Reset mid-transaction, with the pointer left off zero.
    randomize_req(0);
    do_txn(4'b0001, 0, 0);
    for (int i = 0; i < 4; i++) randomize_req(i);
    req_valid = 4'b1111; pack();
    @(negedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_cmp", {cmp_op, cmp_b, cmp_c}, 0);
    chk("mid_rst_count", cmp_count, 0);
    chk("mid_rst_flags", {rsp_flags, rsp_hit}, 0);
    req_valid = '0;
    @(negedge clk); rst = 1'b0;
    m_ptr = 0; m_cnt = 0;
    @(negedge clk);
    do_txn(4'b1111, 0, 0);

    // NaN operand.
    op_a[3] = 2'd1; b_a[3] = 32'h7FC0_0000; c_a[3] = 32'h7FC0_0000;
    do_txn(4'b1000, 0, 0);
`ifdef FCOMP_SCHED_NAN_EN
    chk("nan_seen", nan_seen, 1);
    op_a[0] = 2'd1; b_a[0] = 32'h3F80_0000; c_a[0] = 32'h3F80_0000;
    do_txn(4'b0001, 0, 0);
    chk("nan_seen_sticky", nan_seen, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
